// File: rtl/axi_lite_mmio_master_if.sv
// ============================================================================
// Module   : axi_lite_mmio_master_if
// Purpose  : Core-side MMIO request/response and AXI4-Lite channel bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface axi_lite_mmio_master_if #(
    parameter int AW = 28
) ();
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_err;

    logic [AW-1:0] m_axi_awaddr;
    logic          m_axi_awvalid;
    logic          m_axi_awready;
    logic [31:0]   m_axi_wdata;
    logic          m_axi_wvalid;
    logic          m_axi_wready;
    logic [1:0]    m_axi_bresp;
    logic          m_axi_bvalid;
    logic          m_axi_bready;
    logic [AW-1:0] m_axi_araddr;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [31:0]   m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rvalid;
    logic          m_axi_rready;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wvalid, m_axi_bready,
        output m_axi_araddr, m_axi_arvalid, m_axi_rready,
        input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
        input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wvalid, m_axi_bready,
        input  m_axi_araddr, m_axi_arvalid, m_axi_rready,
        output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
        output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
    );
endinterface

`default_nettype wire

// File: rtl/axi_lite_mmio_master.sv
// ============================================================================
// Module   : axi_lite_mmio_master
// Purpose  : Single-outstanding AXI4-Lite master for 32-bit MMIO with timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axi_lite_mmio_master #(
    parameter int AW      = 28,
    parameter int TIMEOUT = 1024
) (
    input  wire logic               clk,
    input  wire logic               rst,
    axi_lite_mmio_master_if.master  bus
);
    localparam int            CW        = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT);
    localparam bit            C_TO_EN   = (TIMEOUT != 0);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B, S_RESP} state_t;

    state_t        r_state,      w_state;
    logic          r_req_ready,  w_req_ready;
    logic          r_resp_valid, w_resp_valid;
    logic          r_resp_err,   w_resp_err;
    logic [31:0]   r_resp_rdata, w_resp_rdata;
    logic [AW-1:0] r_addr,       w_addr;
    logic [31:0]   r_wdata,      w_wdata;
    logic          r_awvalid,    w_awvalid;
    logic          r_wvalid,     w_wvalid;
    logic          r_bready,     w_bready;
    logic          r_arvalid,    w_arvalid;
    logic          r_rready,     w_rready;
    logic [CW-1:0] r_cnt,        w_cnt;

    logic          w_cnt_inc_sat;
    logic [CW-1:0] w_cnt_inc;
    logic          w_expired;
    logic          w_timeout;
    logic          w_aw_done;
    logic          w_w_done;

    // Expiry is judged on the incremented count so a dead slave sees exactly TIMEOUT valid cycles
    assign w_cnt_inc_sat = (r_cnt == C_TIMEOUT);
    assign w_cnt_inc     = w_cnt_inc_sat ? r_cnt : r_cnt + 1'b1;
    assign w_expired     = C_TO_EN && (w_cnt_inc == C_TIMEOUT);
    assign w_aw_done     = !r_awvalid || bus.m_axi_awready;
    assign w_w_done      = !r_wvalid  || bus.m_axi_wready;

    always_comb begin
        w_state      = r_state;
        w_req_ready  = r_req_ready;
        w_resp_valid = r_resp_valid;
        w_resp_err   = r_resp_err;
        w_resp_rdata = r_resp_rdata;
        w_addr       = r_addr;
        w_wdata      = r_wdata;
        w_awvalid    = r_awvalid;
        w_wvalid     = r_wvalid;
        w_bready     = r_bready;
        w_arvalid    = r_arvalid;
        w_rready     = r_rready;
        w_cnt        = r_cnt;
        w_timeout    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid && r_req_ready) begin
                    w_req_ready = 1'b0;
                    w_addr      = bus.req_addr;
                    w_wdata     = bus.req_wdata;
                    w_cnt       = '0;
                    if (bus.req_write) begin
                        w_awvalid = 1'b1;
                        w_wvalid  = 1'b1;
                        w_state   = S_WR;
                    end else begin
                        w_arvalid = 1'b1;
                        w_state   = S_AR;
                    end
                end
            end
            S_AR: begin
                w_cnt = w_cnt_inc;
                if (bus.m_axi_arready) begin
                    w_arvalid = 1'b0;
                    w_rready  = 1'b1;
                    w_state   = S_R;
                end else begin
                    w_timeout = w_expired;
                end
            end
            S_R: begin
                w_cnt = w_cnt_inc;
                if (bus.m_axi_rvalid) begin
                    w_rready     = 1'b0;
                    w_resp_rdata = bus.m_axi_rdata;
                    w_resp_err   = |bus.m_axi_rresp;
                    w_resp_valid = 1'b1;
                    w_state      = S_RESP;
                end else begin
                    w_timeout = w_expired;
                end
            end
            S_WR: begin
                w_cnt = w_cnt_inc;
                if (r_awvalid && bus.m_axi_awready) w_awvalid = 1'b0;
                if (r_wvalid && bus.m_axi_wready)   w_wvalid  = 1'b0;
                if (w_aw_done && w_w_done) begin
                    w_bready = 1'b1;
                    w_state  = S_B;
                end else begin
                    w_timeout = w_expired;
                end
            end
            S_B: begin
                w_cnt = w_cnt_inc;
                if (bus.m_axi_bvalid) begin
                    w_bready     = 1'b0;
                    w_resp_err   = |bus.m_axi_bresp;
                    w_resp_rdata = '0;
                    w_resp_valid = 1'b1;
                    w_state      = S_RESP;
                end else begin
                    w_timeout = w_expired;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    w_resp_valid = 1'b0;
                    w_req_ready  = 1'b1;
                    w_state      = S_IDLE;
                end
            end
            default: begin
                w_req_ready = 1'b1;
                w_state     = S_IDLE;
            end
        endcase

        // Abandon the bus cycle; late R/B beats stay unconsumed since rready/bready drop
        if (w_timeout) begin
            w_arvalid    = 1'b0;
            w_rready     = 1'b0;
            w_awvalid    = 1'b0;
            w_wvalid     = 1'b0;
            w_bready     = 1'b0;
            w_resp_err   = 1'b1;
            w_resp_rdata = '0;
            w_resp_valid = 1'b1;
            w_state      = S_RESP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state;
            r_req_ready  <= w_req_ready;
            r_resp_valid <= w_resp_valid;
            r_resp_err   <= w_resp_err;
            r_resp_rdata <= w_resp_rdata;
            r_addr       <= w_addr;
            r_wdata      <= w_wdata;
            r_awvalid    <= w_awvalid;
            r_wvalid     <= w_wvalid;
            r_bready     <= w_bready;
            r_arvalid    <= w_arvalid;
            r_rready     <= w_rready;
            r_cnt        <= w_cnt;
        end
    end

    assign bus.req_ready     = r_req_ready;
    assign bus.resp_valid    = r_resp_valid;
    assign bus.resp_err      = r_resp_err;
    assign bus.resp_rdata    = r_resp_rdata;
    assign bus.m_axi_awaddr  = r_addr;
    assign bus.m_axi_araddr  = r_addr;
    assign bus.m_axi_wdata   = r_wdata;
    assign bus.m_axi_awvalid = r_awvalid;
    assign bus.m_axi_wvalid  = r_wvalid;
    assign bus.m_axi_bready  = r_bready;
    assign bus.m_axi_arvalid = r_arvalid;
    assign bus.m_axi_rready  = r_rready;

endmodule

`default_nettype wire
